// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART types, frame constants and baud helpers        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_e;

  // Clocks per bit; callers must keep the result at 4 or above.
  function automatic int calc_cpb(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half(input int cpb);
    return cpb / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_sync : 2-flop synchronizer for asynchronous pin inputs        |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx : oversampling 8N1 receiver with sticky flag, framing/overrun |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_flag_clr,
  output logic [7:0] rx_data,
  output logic       rx_flag,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB = calc_cpb(CLK_FREQ, BAUD_RATE);
  localparam int HALF = calc_half(CPB);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] C_CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);
  localparam logic [2:0]    C_IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic w_rx_s;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  uart_rx_state_e r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]     r_bit_idx, w_bit_idx_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic           w_frame_ok;
  logic           w_frame_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_frame_ok    = 1'b0;
    w_frame_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end
      START: begin
        // Start bit must still be low at its midpoint, else it was a glitch.
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt   = DATA;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {w_rx_s, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == C_IDX_LAST) begin
            w_state_nxt = STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_frame_ok  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not look like a fresh start bit.
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_flag   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_frame_ok) begin
        rx_data <= r_shift;
      end

      // A new byte takes priority over a clear landing in the same cycle.
      if (w_frame_ok) begin
        rx_flag <= 1'b1;
      end else if (rx_flag_clr) begin
        rx_flag <= 1'b0;
      end

      if (w_frame_ok && rx_flag && !rx_flag_clr) begin
        overrun <= 1'b1;
      end else if (rx_flag_clr) begin
        overrun <= 1'b0;
      end

      if (w_frame_ok) begin
        frame_err <= 1'b0;
      end else if (w_frame_bad) begin
        frame_err <= 1'b1;
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire
